// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - Shared opcodes, control-bit indices and fetch words for the SAP microsequencer.
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_STA = 4'h3,
        OP_LDI = 4'h4,
        OP_JMP = 4'h5,
        OP_JC  = 4'h6,
        OP_JZ  = 4'h7,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } seq_state_t;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    localparam logic [15:0] FETCH0 = 16'((1 << CW_CO) | (1 << CW_MI));
    localparam logic [15:0] FETCH1 = 16'((1 << CW_RO) | (1 << CW_II) | (1 << CW_CE));

endpackage

// File: rtl/sap_control_rom.sv
// rtl/sap_control_rom.sv - Combinational microcode: (opcode, step, flags) -> 16-bit control word.
module sap_control_rom
    import sap_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [STEP_WIDTH-1:0]   step,
    input  logic                    flag_c,
    input  logic                    flag_z,
    output logic [15:0]             word
);

    logic [31:0] op_ext;
    logic [31:0] exec_idx;

    assign op_ext   = 32'(opcode);
    assign exec_idx = 32'(step) - 32'd2;

    always_comb begin
        word = '0;
        if (step == '0) begin
            word = FETCH0;
        end else if (step == STEP_WIDTH'(1)) begin
            word = FETCH1;
        end else begin
            case (op_ext)
                32'(OP_LDA): begin
                    case (exec_idx)
                        32'd0:   begin word[CW_IO] = 1'b1; word[CW_MI] = 1'b1; end
                        32'd1:   begin word[CW_RO] = 1'b1; word[CW_AI] = 1'b1; end
                        default: ;
                    endcase
                end
                32'(OP_ADD), 32'(OP_SUB): begin
                    case (exec_idx)
                        32'd0:   begin word[CW_IO] = 1'b1; word[CW_MI] = 1'b1; end
                        32'd1:   begin word[CW_RO] = 1'b1; word[CW_BI] = 1'b1; end
                        32'd2: begin
                            word[CW_EO] = 1'b1;
                            word[CW_AI] = 1'b1;
                            word[CW_FI] = 1'b1;
                            word[CW_SU] = (op_ext == 32'(OP_SUB));
                        end
                        default: ;
                    endcase
                end
                32'(OP_STA): begin
                    case (exec_idx)
                        32'd0:   begin word[CW_IO] = 1'b1; word[CW_MI] = 1'b1; end
                        32'd1:   begin word[CW_AO] = 1'b1; word[CW_RI] = 1'b1; end
                        default: ;
                    endcase
                end
                32'(OP_LDI): if (exec_idx == 32'd0) begin word[CW_IO] = 1'b1; word[CW_AI] = 1'b1; end
                32'(OP_JMP): if (exec_idx == 32'd0) begin word[CW_IO] = 1'b1; word[CW_J] = 1'b1; end
                // Conditional jumps only look at the flags in their single execute step.
                32'(OP_JC):  if (exec_idx == 32'd0 && flag_c) begin word[CW_IO] = 1'b1; word[CW_J] = 1'b1; end
                32'(OP_JZ):  if (exec_idx == 32'd0 && flag_z) begin word[CW_IO] = 1'b1; word[CW_J] = 1'b1; end
                32'(OP_OUT): if (exec_idx == 32'd0) begin word[CW_AO] = 1'b1; word[CW_OI] = 1'b1; end
                32'(OP_HLT): if (exec_idx == 32'd0) word[CW_HLT] = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sap_microsequencer.sv
// rtl/sap_microsequencer.sv - SAP control sequencer; define SAP_SINGLE_STEP_EN to add step_mode/step_req single-stepping.
module sap_microsequencer
    import sap_pkg::*;
#(
    parameter int CW_WIDTH     = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_STEPS    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [OPCODE_WIDTH-1:0]      opcode,
    input  logic                         flag_c,
    input  logic                         flag_z,
    input  logic                         resume,
`ifdef SAP_SINGLE_STEP_EN
    input  logic                         step_mode,
    input  logic                         step_req,
`endif
    output logic [CW_WIDTH-1:0]          ctrl_word,
    output logic [$clog2(MAX_STEPS)-1:0] step,
    output logic                         halted,
    output logic                         instr_done,
    output logic                         clk_en
);

    localparam int SW = $clog2(MAX_STEPS);

    seq_state_t    state_q, state_d;
    logic [SW-1:0] step_q, step_d, step_plus;
    logic [15:0]   cur_word, nxt_word;
    logic          last_step, done_run, advance;

    assign step_plus = step_q + SW'(1);

    sap_control_rom #(.OPCODE_WIDTH(OPCODE_WIDTH), .STEP_WIDTH(SW)) u_rom_cur (
        .opcode (opcode),
        .step   (step_q),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .word   (cur_word)
    );

    // Lookahead decode of the following step decides early end-of-instruction.
    sap_control_rom #(.OPCODE_WIDTH(OPCODE_WIDTH), .STEP_WIDTH(SW)) u_rom_nxt (
        .opcode (opcode),
        .step   (step_plus),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .word   (nxt_word)
    );

    // Fetch never ends early, so an empty step 2 still gets its one dead cycle.
    assign last_step = (32'(step_q) == 32'(MAX_STEPS - 1));
    assign done_run  = last_step || ((32'(step_q) >= 32'd2) && (nxt_word == '0));

`ifdef SAP_SINGLE_STEP_EN
    logic req_q;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= step_req;
        end
    end

    assign advance = ~step_mode | (step_req & ~req_q);
`else
    assign advance = 1'b1;
`endif

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (advance) begin
            case (state_q)
                ST_RUN: begin
                    if (cur_word[CW_HLT]) begin
                        state_d = ST_HALTED;
                    end else if (done_run) begin
                        step_d = '0;
                    end else begin
                        step_d = step_plus;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_d = ST_RUN;
                        step_d  = '0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign halted     = (state_q == ST_HALTED);
    assign step       = step_q;
    assign instr_done = reset_n && !halted && done_run;
    assign clk_en     = ~reset_n | (~halted & advance);

    always_comb begin
        ctrl_word = '0;
        if (!reset_n) begin
            ctrl_word = '0;
        end else if (halted) begin
            ctrl_word[CW_HLT] = 1'b1;
        end else begin
            ctrl_word[15:0] = cur_word;
        end
    end

endmodule

// File: tb/tb_sap_microsequencer.sv
// tb/tb_sap_microsequencer.sv - Self-checking bench for sap_microsequencer against an instruction-level model.
module tb_sap_microsequencer;

    localparam int MAX_STEPS = 8;
    localparam int SW        = 3;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
    localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
    localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic          flag_c = 1'b0;
    logic          flag_z = 1'b0;
    logic          resume = 1'b0;
`ifdef SAP_SINGLE_STEP_EN
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
`endif
    logic [15:0]   ctrl_word;
    logic [SW-1:0] step;
    logic          halted;
    logic          instr_done;
    logic          clk_en;

    int checks = 0;
    int failures = 0;
    logic [15:0] seq[$];

    sap_microsequencer #(.CW_WIDTH(16), .OPCODE_WIDTH(4), .MAX_STEPS(MAX_STEPS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .resume     (resume),
`ifdef SAP_SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step_req   (step_req),
`endif
        .ctrl_word  (ctrl_word),
        .step       (step),
        .halted     (halted),
        .instr_done (instr_done),
        .clk_en     (clk_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-instruction word list: fetch, execute words, at least one (possibly empty) execute cycle.
    function automatic void build_seq(input logic [3:0] op, input logic fc, input logic fz);
        seq = {B_CO | B_MI, B_RO | B_II | B_CE};
        case (op)
            4'h0: begin seq.push_back(B_IO | B_MI); seq.push_back(B_RO | B_AI); end
            4'h1: begin seq.push_back(B_IO | B_MI); seq.push_back(B_RO | B_BI); seq.push_back(B_EO | B_AI | B_FI); end
            4'h2: begin seq.push_back(B_IO | B_MI); seq.push_back(B_RO | B_BI); seq.push_back(B_EO | B_AI | B_SU | B_FI); end
            4'h3: begin seq.push_back(B_IO | B_MI); seq.push_back(B_AO | B_RI); end
            4'h4: seq.push_back(B_IO | B_AI);
            4'h5: seq.push_back(B_IO | B_J);
            4'h6: seq.push_back(fc ? (B_IO | B_J) : 16'h0000);
            4'h7: seq.push_back(fz ? (B_IO | B_J) : 16'h0000);
            4'hE: seq.push_back(B_AO | B_OI);
            4'hF: seq.push_back(B_HLT);
            default: seq.push_back(16'h0000);
        endcase
        while (seq.size() > MAX_STEPS) void'(seq.pop_back());
    endfunction

    task automatic run_instr(input logic [3:0] op, input int hold);
        opcode = op;
        build_seq(op, flag_c, flag_z);
        for (int k = 0; k < seq.size(); k++) begin
            chk("step", 32'(step), k);
            chk("ctrl_word", 32'(ctrl_word), 32'(seq[k]));
            chk("instr_done", 32'(instr_done), 32'(k == seq.size() - 1));
            chk("halted", 32'(halted), 0);
            chk("clk_en", 32'(clk_en), 1);
            if (k >= 2) begin
                flag_c = 1'($urandom);
                flag_z = 1'($urandom);
            end
            resume = seq[k][15] ? 1'b0 : 1'($urandom);
            tick();
        end
        if (op == 4'hF) begin
            for (int h = 0; h < hold; h++) begin
                chk("halt_halted", 32'(halted), 1);
                chk("halt_clk_en", 32'(clk_en), 0);
                chk("halt_ctrl_word", 32'(ctrl_word), 32'h8000);
                chk("halt_instr_done", 32'(instr_done), 0);
                chk("halt_step", 32'(step), 2);
                tick();
            end
            resume = 1'b1;
            tick();
            resume = 1'b0;
            chk("resume_halted", 32'(halted), 0);
            chk("resume_fetch", 32'(ctrl_word), 32'h4004);
        end
        resume = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_ctrl_word", 32'(ctrl_word), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_instr_done", 32'(instr_done), 0);
        chk("rst_clk_en", 32'(clk_en), 1);
        tick();
        reset_n = 1'b1;
        #1;

        run_instr(4'h0, 0);
        run_instr(4'h1, 0);
        flag_c = 1'b0; run_instr(4'h6, 0);
        flag_c = 1'b1; run_instr(4'h6, 0);
        flag_z = 1'b0; run_instr(4'h7, 0);
        flag_z = 1'b1; run_instr(4'h7, 0);
        run_instr(4'hF, 10);

        opcode = 4'h1;
        tick(); tick(); tick();
        chk("midadd_step", 32'(step), 3);
        chk("midadd_word", 32'(ctrl_word), 32'h1020);
        reset_n = 1'b0;
        #1;
        chk("async_rst_ctrl_word", 32'(ctrl_word), 0);
        chk("async_rst_step", 32'(step), 0);
        chk("async_rst_instr_done", 32'(instr_done), 0);
        chk("async_rst_clk_en", 32'(clk_en), 1);
        tick();
        reset_n = 1'b1;
        #1;
        run_instr(4'h1, 0);

        for (int n = 0; n < 80; n++) begin
            flag_c = 1'($urandom);
            flag_z = 1'($urandom);
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(1, 5)));
        end

`ifdef SAP_SINGLE_STEP_EN
        opcode = 4'h0;
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ss_frozen_step", 32'(step), 0);
            chk("ss_frozen_clk_en", 32'(clk_en), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tick();
            chk("ss_pulse_step", 32'(step), 32'(i + 1));
        end
        step_mode = 1'b0;
        tick();
        chk("ss_release_step", 32'(step), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
